// File: rtl/fp32_pkg.sv
// FP32 field layout, flag encoding and shared types for the divider result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp32_pkg;

    // IEEE-754 single-precision field boundaries.
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam logic [EXP_MSB-EXP_LSB:0] EXP_MAX = 8'hFF;

    // Bit positions inside the 4-bit classification flags.
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_SIGN = 0;

    typedef struct packed {
        logic                     sign;
        logic [EXP_MSB-EXP_LSB:0] exp;
        logic [FRAC_MSB:0]        frac;
    } fp32_t;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/fp32_classify.sv
// Classifies an FP32 word into {nan, inf, zero, sign} flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   in_word  FP32 word {sign, exp, frac}
//   flags    {nan, inf, zero, sign} at FLAG_* positions
module fp32_classify
    import fp32_pkg::*;
(
    input  fp32_t  in_word,
    output flags_t flags
);

    logic exp_max;
    logic frac_nz;

    always_comb begin
        exp_max = (in_word.exp == EXP_MAX);
        frac_nz = |in_word.frac;

        flags            = '0;
        flags[FLAG_NAN]  = exp_max && frac_nz;
        flags[FLAG_INF]  = exp_max && !frac_nz;
        // The divider never emits subnormals, so any word with a zero
        // exponent is reported as zero regardless of its fraction.
        flags[FLAG_ZERO] = (in_word.exp == '0);
        flags[FLAG_SIGN] = in_word.sign;
    end

endmodule

// File: rtl/fp_div_result_fifo.sv
// Captures divider results, tags them with class flags and buffers them in a small FIFO.
// Latency: one cycle from push into an empty FIFO to out_valid; no bypass.
// Backpressure: in_ready drops when full, derived from registered occupancy only.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   in_valid/in_data/in_ready  divider result input handshake
//   out_valid/out_data/
//   out_flags/out_ready        head-of-FIFO output handshake (data/flags zero when empty)
//   count                      occupancy 0..DEPTH
//   nan_cnt/nan_cnt_clr        saturating count of NaN words accepted, and its clear
module fp_div_result_fifo
    import fp32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,  // only 32 is meaningful: words are FP32
    parameter int DEPTH      = 4,   // power of two, >= 2
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [3:0]               out_flags,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_WIDTH-1:0]     nan_cnt,
    input  logic                     nan_cnt_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] NAN_MAX  = {CNT_WIDTH{1'b1}};

    typedef struct packed {
        flags_t                flags;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0]   nan_cnt_q, nan_cnt_d;

    fp32_t                  in_word;
    flags_t                 in_flags;
    logic                   push;
    logic                   pop;

    assign in_word = fp32_t'(in_data);

    fp32_classify u_classify (
        .in_word (in_word),
        .flags   (in_flags)
    );

    // Handshake outputs depend only on registered occupancy, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (count_q != OCC_FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q].data  : '0;
    assign out_flags = out_valid ? mem_q[rd_ptr_q].flags : '0;
    assign count     = count_q;
    assign nan_cnt   = nan_cnt_q;

    always_comb begin
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        nan_cnt_d = nan_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{flags: in_flags, data: in_data};
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        // Clear takes priority over a same-cycle NaN push.
        if (nan_cnt_clr) begin
            nan_cnt_d = '0;
        end else if (push && in_flags[FLAG_NAN] && (nan_cnt_q != NAN_MAX)) begin
            nan_cnt_d = nan_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            nan_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_div_result_fifo.sv
// Directed bench for the FP32 divider result FIFO.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised via out_ready low/high phases and full-FIFO offers.
module tb_fp_div_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic        out_ready;
    logic [2:0]  count;
    logic [7:0]  nan_cnt;
    logic        nan_cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    fp_div_result_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CNT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_flags   (out_flags),
        .out_ready   (out_ready),
        .count       (count),
        .nan_cnt     (nan_cnt),
        .nan_cnt_clr (nan_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        nan_cnt_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_nan_cnt",   32'(nan_cnt),   32'd0);

        // Single word, one-cycle latency, then popped
        in_valid  = 1'b1;
        in_data   = 32'h3F80_0000;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data",  out_data,       32'h3F80_0000);
        chk("one_flags", 32'(out_flags), 32'b0000);
        chk("one_count", 32'(count),     32'd1);
        tick();
        chk("one_pop_count", 32'(count),     32'd0);
        chk("one_pop_valid", 32'(out_valid), 32'd0);
        chk("one_pop_data",  out_data,       32'd0);

        // Fill with special values under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7FC0_0000; tick();
        in_data   = 32'h7F80_0000; tick();
        in_data   = 32'h8000_0000; tick();
        in_data   = 32'h0000_0001; tick();
        chk("full_count",    32'(count),    32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_nan_cnt",  32'(nan_cnt),  32'd1);

        // Offer while full, no pop: dropped
        in_data = 32'h1234_5678;
        tick();
        chk("full_drop_count", 32'(count), 32'd4);

        // Offer while full with a concurrent pop: push still ignored
        chk("head0_data",  out_data,       32'h7FC0_0000);
        chk("head0_flags", 32'(out_flags), 32'b1000);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fullpop_count",    32'(count),    32'd3);
        chk("fullpop_in_ready", 32'(in_ready), 32'd1);

        // Drain the rest in order
        chk("head1_data",  out_data,       32'h7F80_0000);
        chk("head1_flags", 32'(out_flags), 32'b0100);
        tick();
        chk("head2_data",  out_data,       32'h8000_0000);
        chk("head2_flags", 32'(out_flags), 32'b0011);
        tick();
        chk("head3_data",  out_data,       32'h0000_0001);
        chk("head3_flags", 32'(out_flags), 32'b0010);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count),     32'd0);

        // Half-full streaming across pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4000_0100; tick();
        in_data   = 32'h4000_0101; tick();
        chk("half_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stream_head_%0d", i), out_data, 32'h4000_0100 + 32'(i));
            in_data = 32'h4000_0102 + 32'(i);
            tick();
            chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        chk("stream_tail0", out_data, 32'h4000_0114);
        tick();
        chk("stream_tail1", out_data, 32'h4000_0115);
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);

        // NaN counter: clear, then saturate
        nan_cnt_clr = 1'b1;
        tick();
        nan_cnt_clr = 1'b0;
        chk("nan_clr0", 32'(nan_cnt), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 1) begin
                chk("nan_flags", 32'(out_flags), 32'b1001);
                chk("nan_cnt_1", 32'(nan_cnt),   32'd1);
            end
            if (i == 254) chk("nan_cnt_254", 32'(nan_cnt), 32'd254);
            if (i == 255) chk("nan_cnt_255", 32'(nan_cnt), 32'd255);
        end
        chk("nan_sat", 32'(nan_cnt), 32'd255);
        chk("nan_stream_count", 32'(count), 32'd1);
        nan_cnt_clr = 1'b1;
        tick();
        nan_cnt_clr = 1'b0;
        in_valid    = 1'b0;
        chk("nan_clr_wins", 32'(nan_cnt), 32'd0);
        tick();
        chk("nan_drained", 32'(count), 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7FC0_0001; tick();
        in_data   = 32'h4000_0000; tick();
        in_data   = 32'h4040_0000; tick();
        in_valid  = 1'b0;
        chk("pre_rst_count", 32'(count),   32'd3);
        chk("pre_rst_nan",   32'(nan_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_count",    32'(count),     32'd0);
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_nan",      32'(nan_cnt),   32'd0);
        chk("mid_rst_data",     out_data,       32'd0);
        in_valid = 1'b1;
        in_data  = 32'hC049_0FDB;
        tick();
        in_valid = 1'b0;
        chk("post_rst_data",  out_data,       32'hC049_0FDB);
        chk("post_rst_flags", 32'(out_flags), 32'b0001);
        chk("post_rst_count", 32'(count),     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
